// File: rtl/real_to_iq.sv
// Real IF to complex baseband downconverter: NCO mixer (cos / -sin) followed by
// a boxcar integrate-and-dump decimator.
module real_to_iq #(
    parameter logic [31:0] PHASE_STEP = 32'd13421773,
    parameter int unsigned DEC        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [15:0] real_in,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out,
    output logic               out_valid
);

    localparam int unsigned SHIFT = $clog2(DEC);
    localparam int unsigned CNT_W = (SHIFT < 1) ? 1 : SHIFT;
    localparam int unsigned ACC_W = 24;

    // First quadrant (k = 0..64) of round(32767*sin(2*pi*k/256)); the rest follows by symmetry.
    function automatic logic signed [15:0] quarter_sine(input logic [6:0] k);
        logic signed [15:0] v;
        case (k)
            7'd0:  v = 16'sd0;     7'd1:  v = 16'sd804;   7'd2:  v = 16'sd1608;  7'd3:  v = 16'sd2411;
            7'd4:  v = 16'sd3212;  7'd5:  v = 16'sd4011;  7'd6:  v = 16'sd4808;  7'd7:  v = 16'sd5602;
            7'd8:  v = 16'sd6393;  7'd9:  v = 16'sd7179;  7'd10: v = 16'sd7962;  7'd11: v = 16'sd8739;
            7'd12: v = 16'sd9512;  7'd13: v = 16'sd10278; 7'd14: v = 16'sd11039; 7'd15: v = 16'sd11793;
            7'd16: v = 16'sd12539; 7'd17: v = 16'sd13279; 7'd18: v = 16'sd14010; 7'd19: v = 16'sd14732;
            7'd20: v = 16'sd15446; 7'd21: v = 16'sd16151; 7'd22: v = 16'sd16846; 7'd23: v = 16'sd17530;
            7'd24: v = 16'sd18204; 7'd25: v = 16'sd18868; 7'd26: v = 16'sd19519; 7'd27: v = 16'sd20159;
            7'd28: v = 16'sd20787; 7'd29: v = 16'sd21403; 7'd30: v = 16'sd22005; 7'd31: v = 16'sd22594;
            7'd32: v = 16'sd23170; 7'd33: v = 16'sd23731; 7'd34: v = 16'sd24279; 7'd35: v = 16'sd24811;
            7'd36: v = 16'sd25329; 7'd37: v = 16'sd25832; 7'd38: v = 16'sd26319; 7'd39: v = 16'sd26790;
            7'd40: v = 16'sd27245; 7'd41: v = 16'sd27683; 7'd42: v = 16'sd28105; 7'd43: v = 16'sd28510;
            7'd44: v = 16'sd28898; 7'd45: v = 16'sd29268; 7'd46: v = 16'sd29621; 7'd47: v = 16'sd29956;
            7'd48: v = 16'sd30273; 7'd49: v = 16'sd30571; 7'd50: v = 16'sd30852; 7'd51: v = 16'sd31113;
            7'd52: v = 16'sd31356; 7'd53: v = 16'sd31580; 7'd54: v = 16'sd31785; 7'd55: v = 16'sd31971;
            7'd56: v = 16'sd32137; 7'd57: v = 16'sd32285; 7'd58: v = 16'sd32412; 7'd59: v = 16'sd32521;
            7'd60: v = 16'sd32609; 7'd61: v = 16'sd32678; 7'd62: v = 16'sd32728; 7'd63: v = 16'sd32757;
            default: v = 16'sd32767;
        endcase
        return v;
    endfunction

    function automatic logic signed [15:0] sine(input logic [7:0] idx);
        logic [6:0]         off;
        logic signed [15:0] mag;
        off = idx[6] ? 7'(7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        mag = quarter_sine(off);
        return idx[7] ? -mag : mag;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sd32767;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return 16'(v);
    endfunction

    logic [31:0]              phase_acc;
    logic [7:0]               lut_idx;
    logic signed [15:0]       x_r, cos_r, sin_r;
    logic signed [31:0]       prod_i, prod_q;
    logic signed [15:0]       mix_i, mix_q;
    logic signed [ACC_W-1:0]  acc_i, acc_q;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic [CNT_W-1:0]         cnt;
    logic                     v1, v2, v3;

    assign lut_idx = phase_acc[31:24];
    assign sum_i   = acc_i + ACC_W'(mix_i);
    assign sum_q   = acc_q + ACC_W'(mix_q);

    // Three-stage mixer pipeline feeding the integrate-and-dump.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_acc <= '0;
            x_r       <= '0;
            cos_r     <= '0;
            sin_r     <= '0;
            prod_i    <= '0;
            prod_q    <= '0;
            mix_i     <= '0;
            mix_q     <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= 1'b0;

            if (in_valid) begin
                x_r       <= real_in;
                sin_r     <= sine(lut_idx);
                cos_r     <= sine(8'(lut_idx + 8'd64));
                phase_acc <= phase_acc + PHASE_STEP;
            end

            prod_i <= 32'(x_r) * 32'(cos_r);
            prod_q <= -(32'(x_r) * 32'(sin_r));
            mix_i  <= sat16(prod_i >>> 14);
            mix_q  <= sat16(prod_q >>> 14);

            // Boxcar average: the dump includes the sample arriving this cycle.
            if (v3) begin
                if (cnt == CNT_W'(DEC - 1)) begin
                    i_out     <= 16'(sum_i >>> SHIFT);
                    q_out     <= 16'(sum_q >>> SHIFT);
                    acc_i     <= '0;
                    acc_q     <= '0;
                    cnt       <= '0;
                    out_valid <= 1'b1;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= CNT_W'(cnt + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_real_to_iq.sv
// Directed bench for real_to_iq: DC, saturation, gapped input, mid-block reset
// and an upconvert/downconvert round trip.
module tb_real_to_iq;

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic               in_valid = 1'b1;
    logic signed [15:0] real_in  = 16'sd1234;

    logic signed [15:0] dc_i, dc_q, rt_i, rt_q;
    logic               dc_ov, rt_ov;

    real_to_iq #(.PHASE_STEP(32'd0), .DEC(8)) u_dc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .real_in(real_in),
        .i_out(dc_i), .q_out(dc_q), .out_valid(dc_ov)
    );

    real_to_iq #(.PHASE_STEP(32'h1000_0000), .DEC(8)) u_rt (
        .clk(clk), .reset(reset), .in_valid(in_valid), .real_in(real_in),
        .i_out(rt_i), .q_out(rt_q), .out_valid(rt_ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int b2b      = 0;
    logic dc_ov_d = 1'b0;

    int dc_iq[$], dc_qq[$], dc_cq[$];
    int rt_iq[$], rt_qq[$];

    // Collect output strobes away from the active edge.
    always @(negedge clk) begin
        if (dc_ov) begin
            dc_iq.push_back(int'(dc_i));
            dc_qq.push_back(int'(dc_q));
            dc_cq.push_back(cyc);
        end
        if (rt_ov) begin
            rt_iq.push_back(int'(rt_i));
            rt_qq.push_back(int'(rt_q));
        end
        if (dc_ov && dc_ov_d) b2b++;
        dc_ov_d = dc_ov;
    end

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic drive(input logic v, input int d);
        @(negedge clk);
        in_valid = v;
        real_in  = 16'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        real_in  = 16'sd1234;
        repeat (n) @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        real_in  = '0;
    endtask

    task automatic clear_q();
        dc_iq.delete(); dc_qq.delete(); dc_cq.delete();
        rt_iq.delete(); rt_qq.delete();
    endtask

    function automatic int tb_sin(input int k);
        return int'(32767.0 * $sin(2.0 * 3.14159265358979 * real'(k % 256) / 256.0));
    endfunction

    // Unit-gain upconverter model at phase step 2^28 (LUT index advances by 16).
    function automatic int up(input int i, input int q, input int n);
        int idx;
        int r;
        idx = (n * 16) % 256;
        r = (i * tb_sin(idx + 64) - q * tb_sin(idx)) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    int acc_cyc[$];
    int nacc;

    initial begin
        // Reset held three edges with in_valid asserted.
        repeat (3) @(negedge clk);
        check("rst_i", int'(dc_i), 0);
        check("rst_q", int'(dc_q), 0);
        check("rst_ov", int'(dc_ov), 0);
        check("rst_rt_i", int'(rt_i), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        real_in  = '0;
        clear_q();

        // DC, continuous, three blocks.
        acc_cyc.delete();
        for (int k = 1; k <= 24; k++) begin
            drive(1'b1, 1000);
            if (k % 8 == 0) acc_cyc.push_back(cyc);
        end
        idle(8);
        check("dc_count", dc_iq.size(), 3);
        for (int j = 0; j < dc_iq.size() && j < 3; j++) begin
            check("dc_i", dc_iq[j], 1999);
            check("dc_q", dc_qq[j], 0);
            check("dc_lat", dc_cq[j] - acc_cyc[j], 4);
        end
        clear_q();

        // Saturation of the mixer product.
        for (int k = 0; k < 8; k++) drive(1'b1, -32768);
        idle(8);
        check("sat_count", dc_iq.size(), 1);
        for (int j = 0; j < dc_iq.size(); j++) begin
            check("sat_i", dc_iq[j], -32768);
            check("sat_q", dc_qq[j], 0);
        end
        clear_q();

        // Gapped input: alternate valid / idle.
        acc_cyc.delete();
        nacc = 0;
        for (int k = 0; k < 32; k++) begin
            drive(k % 2 == 0, 1000);
            if (k % 2 == 0) begin
                nacc++;
                if (nacc % 8 == 0) acc_cyc.push_back(cyc);
            end
        end
        idle(8);
        check("gap_count", dc_iq.size(), 2);
        for (int j = 0; j < dc_iq.size() && j < 2; j++) begin
            check("gap_i", dc_iq[j], 1999);
            check("gap_q", dc_qq[j], 0);
            check("gap_lat", dc_cq[j] - acc_cyc[j], 4);
        end
        clear_q();

        // Reset mid-block discards partial sums and in-flight samples.
        for (int k = 0; k < 5; k++) drive(1'b1, 5000);
        do_reset(1);
        clear_q();
        for (int k = 0; k < 8; k++) drive(1'b1, 1000);
        idle(8);
        check("mid_count", dc_iq.size(), 1);
        for (int j = 0; j < dc_iq.size(); j++) begin
            check("mid_i", dc_iq[j], 1999);
            check("mid_q", dc_qq[j], 0);
        end

        // Round trip, I only.
        do_reset(2);
        clear_q();
        for (int n = 0; n < 16; n++) drive(1'b1, up(8000, 0, n));
        idle(8);
        check("rt1_count", rt_iq.size(), 2);
        for (int j = 0; j < rt_iq.size(); j++) begin
            check("rt1_i", rt_iq[j], 8000, 40);
            check("rt1_q", rt_qq[j], 0, 40);
        end

        // Round trip, Q only.
        do_reset(2);
        clear_q();
        for (int n = 0; n < 16; n++) drive(1'b1, up(0, 8000, n));
        idle(8);
        check("rt2_count", rt_iq.size(), 2);
        for (int j = 0; j < rt_iq.size(); j++) begin
            check("rt2_i", rt_iq[j], 0, 40);
            check("rt2_q", rt_qq[j], 8000, 40);
        end

        check("b2b_strobe", b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
